multichannel_integrator: RTL and testbench

Time-multiplexed saturating integrator for N independent control channels sharing one adder/clamp datapath. Each channel has a private accumulator updated by channel-tagged error samples and clamped to runtime limits. Sums are computed without wrap-around, and saturation is reported per sample. It sits between the error computation and the PI/PID output stage of multi-phase converter control loops.

---
 rtl/multichannel_integrator.sv | 147 ++++++++++++++
 tb/tb_multichannel_integrator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_integrator.sv
// multichannel_integrator: N-channel saturating integrator, shared datapath.
// Define INTEGRATOR_PRELOAD_EN to add the preload port set.
module multichannel_integrator #(
   parameter int DATA_WIDTH = 16,
   parameter int N_CHANNELS = 4,
   parameter int CH_WIDTH   = $clog2(N_CHANNELS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear_all,
   input  logic                  input_valid,
   input  logic [CH_WIDTH-1:0]   input_channel,
   input  logic [DATA_WIDTH-1:0] error_in,
   input  logic [DATA_WIDTH-1:0] limit_up,
   input  logic [DATA_WIDTH-1:0] limit_down,
`ifdef INTEGRATOR_PRELOAD_EN
   input  logic                  preload_valid,
   input  logic [CH_WIDTH-1:0]   preload_channel,
   input  logic [DATA_WIDTH-1:0] preload_value,
`endif
   output logic                  out_valid,
   output logic [CH_WIDTH-1:0]   out_channel,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  sat_up,
   output logic                  sat_down
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] acc_q [N_CHANNELS];
   logic [DATA_WIDTH-1:0] acc_d [N_CHANNELS];

   logic                  out_valid_q, out_valid_d;
   logic [CH_WIDTH-1:0]   out_ch_q, out_ch_d;
   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic                  sat_up_q, sat_up_d;
   logic                  sat_dn_q, sat_dn_d;

   logic                  pl_v;
   logic [CH_WIDTH-1:0]   pl_ch;
   logic [DATA_WIDTH-1:0] pl_val;

`ifdef INTEGRATOR_PRELOAD_EN
   assign pl_v   = preload_valid;
   assign pl_ch  = preload_channel;
   assign pl_val = preload_value;
`else
   assign pl_v   = 1'b0;
   assign pl_ch  = '0;
   assign pl_val = '0;
`endif

   logic                  ch_ok;
   logic                  take;
   logic [DATA_WIDTH-1:0] rd_acc;
   logic signed [DATA_WIDTH:0] sum_s;
   logic signed [DATA_WIDTH:0] up_s;
   logic signed [DATA_WIDTH:0] dn_s;
   logic [DATA_WIDTH-1:0] res;
   logic                  hit_up;
   logic                  hit_dn;

   assign ch_ok = (32'(input_channel) < 32'(N_CHANNELS));

   // A preload on the same channel wins; clear_all beats everything.
   assign take = input_valid & ch_ok & ~clear_all
               & ~(pl_v & (pl_ch == input_channel));

   // Combinational read of the addressed accumulator.
   always_comb begin
      rd_acc = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
         if (input_channel == CH_WIDTH'(i)) rd_acc = acc_q[i];
      end
   end

   // One extra bit of headroom so the compare never sees a wrapped sum.
   assign sum_s = $signed({error_in[MSB], error_in})
                + $signed({rd_acc[MSB], rd_acc});
   assign up_s  = $signed({limit_up[MSB], limit_up});
   assign dn_s  = $signed({limit_down[MSB], limit_down});

   // Clamp: upper test first, so inverted limits resolve to limit_up.
   always_comb begin
      res    = sum_s[MSB:0];
      hit_up = 1'b0;
      hit_dn = 1'b0;
      if (sum_s > up_s) begin
         res    = limit_up;
         hit_up = 1'b1;
      end else if (sum_s < dn_s) begin
         res    = limit_down;
         hit_dn = 1'b1;
      end
   end

   // Next accumulator state: integrate, then preload, then clear.
   always_comb begin
      for (int i = 0; i < N_CHANNELS; i++) begin
         acc_d[i] = acc_q[i];
         if (take && input_channel == CH_WIDTH'(i)) acc_d[i] = res;
         if (pl_v && pl_ch == CH_WIDTH'(i)) acc_d[i] = pl_val;
         if (clear_all) acc_d[i] = '0;
      end
   end

   // Result registers hold until the next accepted sample.
   always_comb begin
      out_valid_d = take;
      out_ch_d    = out_ch_q;
      out_d       = out_q;
      sat_up_d    = sat_up_q;
      sat_dn_d    = sat_dn_q;
      if (take) begin
         out_ch_d = input_channel;
         out_d    = res;
         sat_up_d = hit_up;
         sat_dn_d = hit_dn;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_CHANNELS; i++) acc_q[i] <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_q       <= '0;
         sat_up_q    <= 1'b0;
         sat_dn_q    <= 1'b0;
      end else begin
         for (int i = 0; i < N_CHANNELS; i++) acc_q[i] <= acc_d[i];
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_q       <= out_d;
         sat_up_q    <= sat_up_d;
         sat_dn_q    <= sat_dn_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_channel = out_ch_q;
   assign out         = out_q;
   assign sat_up      = sat_up_q;
   assign sat_down    = sat_dn_q;

endmodule

// File: tb/tb_multichannel_integrator.sv
// tb_multichannel_integrator: scoreboard bench with a behavioural model.
// Channel port widened to 3 bits so out-of-range indices can be driven.
module tb_multichannel_integrator;

   localparam int DW = 16;
   localparam int NC = 4;
   localparam int CW = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          clear_all = 1'b0;
   logic          input_valid = 1'b0;
   logic [CW-1:0] input_channel = '0;
   logic [DW-1:0] error_in = '0;
   logic [DW-1:0] limit_up = '0;
   logic [DW-1:0] limit_down = '0;
   logic          preload_valid = 1'b0;
   logic [CW-1:0] preload_channel = '0;
   logic [DW-1:0] preload_value = '0;
   logic          out_valid;
   logic [CW-1:0] out_channel;
   logic [DW-1:0] out;
   logic          sat_up;
   logic          sat_down;

   multichannel_integrator #(
      .DATA_WIDTH(DW),
      .N_CHANNELS(NC),
      .CH_WIDTH(CW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .clear_all(clear_all),
      .input_valid(input_valid),
      .input_channel(input_channel),
      .error_in(error_in),
      .limit_up(limit_up),
      .limit_down(limit_down),
`ifdef INTEGRATOR_PRELOAD_EN
      .preload_valid(preload_valid),
      .preload_channel(preload_channel),
      .preload_value(preload_value),
`endif
      .out_valid(out_valid),
      .out_channel(out_channel),
      .out(out),
      .sat_up(sat_up),
      .sat_down(sat_down)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit v;
      int ch;
      int o;
      bit u;
      bit d;
   } exp_t;

   exp_t exp_q[$];
   exp_t last;
   exp_t mon_e;
   int   acc_m[NC];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string n, input int a, input int e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) acc_m[i] = 0;
      last = '{v: 1'b0, ch: 0, o: 0, u: 1'b0, d: 1'b0};
   endtask

   // Drive one cycle of stimulus and record what the outputs must show.
   task automatic step(input bit v, input int ch, input int err,
                       input int up, input int dn, input bit clr,
                       input bit plv, input int plc, input int plval);
      exp_t e;
      int   s;
      @(negedge clock);
      input_valid     = v;
      input_channel   = CW'(ch);
      error_in        = DW'(err);
      limit_up        = DW'(up);
      limit_down      = DW'(dn);
      clear_all       = clr;
      preload_valid   = plv;
      preload_channel = CW'(plc);
      preload_value   = DW'(plval);
      e = last;
      e.v = 1'b0;
      if (clr) begin
         for (int i = 0; i < NC; i++) acc_m[i] = 0;
      end else begin
         if (v && ch < NC && !(plv && plc == ch)) begin
            s = err + acc_m[ch];
            e.v = 1'b1;
            e.ch = ch;
            e.u = 1'b0;
            e.d = 1'b0;
            if (s > up) begin
               e.o = up;
               e.u = 1'b1;
            end else if (s < dn) begin
               e.o = dn;
               e.d = 1'b1;
            end else begin
               e.o = s;
            end
            acc_m[ch] = e.o;
         end
         if (plv && plc < NC) acc_m[plc] = plval;
      end
      last = e;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic smp(input int ch, input int err, input int lim);
      step(1, ch, err, lim, -lim, 0, 0, 0, 0);
   endtask

   // Monitor: one expected record per driven cycle.
   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("out_valid", int'(out_valid), int'(mon_e.v));
         chk("out_channel", int'(out_channel), mon_e.ch);
         chk("out", int'($signed(out)), mon_e.o);
         chk("sat_up", int'(sat_up), int'(mon_e.u));
         chk("sat_down", int'(sat_down), int'(mon_e.d));
      end
   end

   initial begin
      logic signed [DW-1:0] r16;
      int err, up, dn, ch;
      bit plv;
      int plc;
      model_reset();
      #12;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_channel", int'(out_channel), 0);
      chk("rst_out", int'(out), 0);
      chk("rst_sat_up", int'(sat_up), 0);
      chk("rst_sat_down", int'(sat_down), 0);
      reset = 1'b1;

      repeat (3) smp(0, 100, 1000);
      for (int c = 1; c < NC; c++) smp(c, 0, 1000);

      smp(2, 600, 1000);
      smp(2, 600, 1000);
      smp(2, -2000, 1000);

      step(0, 0, 0, 0, 0, 1, 0, 0, 0);
      smp(1, 32000, 32767);
      smp(1, 32000, 32767);

      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) smp(0, 10, 1000);
         else smp(1, -10, 1000);
      end
      smp(0, 0, 1000);
      smp(1, 0, 1000);

      smp(3, 77, 1000);
      step(1, 3, 50, 1000, -1000, 1, 0, 0, 0);
      for (int c = 0; c < NC; c++) smp(c, 0, 1000);
      smp(2, 33, 1000);
      smp(4, 500, 1000);
      smp(7, 500, 1000);
      smp(2, 0, 1000);

`ifdef INTEGRATOR_PRELOAD_EN
      step(1, 1, 7, 1000, -1000, 0, 1, 1, 500);
      smp(1, 5, 1000);
      step(1, 0, 9, 1000, -1000, 0, 1, 3, -4000);
      smp(3, 0, 30000);
      step(1, 2, 9, 1000, -1000, 1, 1, 2, 123);
      smp(2, 0, 1000);
`endif

      smp(0, 250, 1000);
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_valid", int'(out_valid), 0);
      chk("async_rst_out", int'(out), 0);
      chk("async_rst_ch", int'(out_channel), 0);
      exp_q.delete();
      model_reset();
      #1;
      reset = 1'b1;
      for (int c = 0; c < NC; c++) smp(c, 1, 1000);

      for (int k = 0; k < 400; k++) begin
         r16 = DW'($urandom);
         if ($urandom % 2 == 0) err = int'($urandom_range(0, 400)) - 200;
         else err = int'(r16);
         if ($urandom % 8 == 0) begin
            r16 = DW'($urandom);
            up = int'(r16);
            r16 = DW'($urandom);
            dn = int'(r16);
         end else begin
            up = int'($urandom_range(0, 32767));
            dn = -int'($urandom_range(0, 32768));
         end
         if ($urandom % 8 == 0) ch = 4 + int'($urandom % 4);
         else ch = int'($urandom % 4);
`ifdef INTEGRATOR_PRELOAD_EN
         plv = ($urandom % 8 == 0);
         plc = int'($urandom % 4);
`else
         plv = 1'b0;
         plc = 0;
`endif
         r16 = DW'($urandom);
         step($urandom % 4 != 0, ch, err, up, dn,
              $urandom % 32 == 0, plv, plc, int'(r16));
      end

      idle();
      repeat (4) @(posedge clock);
      #2;
      chk("drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
